// File: rtl/fpu_issue_pkg.sv
// fpu_issue_pkg: shared state encoding and defaults for the FPU issue/writeback sequencer.
package fpu_issue_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WB} state_t;
  localparam int TIMEOUT_CYCLES_DEF = 64;
endpackage

// File: rtl/fpu_issue_ctrl_timeout.sv
// fpu_issue_timeout: WAIT-cycle watchdog with a sticky error flag, used only
// when FPU_ISSUE_TIMEOUT_EN is defined.
module fpu_issue_timeout
  import fpu_issue_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_b,
  input  logic i_clr,
  input  logic i_wait,
  input  logic i_done,
  output logic o_expire,
  output logic o_err
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] r_cnt;
  logic          r_err;
  // a done arriving on the limit cycle takes priority over the abort
  assign o_expire = i_wait && !i_done && (r_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign o_err    = r_err;
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_cnt <= i_clr ? '0 : i_wait ? r_cnt + 1'b1 : r_cnt;
      if (o_expire) r_err <= 1'b1;
    end
  end
endmodule

// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: stalls decode while a multi-cycle FPU op runs, then writes the
// result to the FP or integer regfile. FPU_ISSUE_TIMEOUT_EN adds a WAIT watchdog.
module fpu_issue_ctrl
  import fpu_issue_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              fpu_or_alu,
  input  logic              fp_write_en,
  input  logic [3:0]        fpu_opcode,
  input  logic              halted,
  input  logic [DATA_W-1:0] fs_data,
  input  logic [DATA_W-1:0] ft_data,
  input  logic [4:0]        dest_addr,
  output logic              fpu_start,
  output logic [3:0]        fpu_op,
  output logic [DATA_W-1:0] fpu_a,
  output logic [DATA_W-1:0] fpu_b,
  input  logic              fpu_done,
  input  logic [DATA_W-1:0] fpu_result,
  output logic              stall,
  output logic              fp_wr_en,
  output logic              int_wr_en,
  output logic [4:0]        wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              timeout_err
);
  state_t            r_state;
  logic              r_fpw;
  logic [3:0]        r_op;
  logic [DATA_W-1:0] r_a, r_b, r_res;
  logic [4:0]        r_dest;
  logic              w_accept, w_expire, w_err;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

`ifdef FPU_ISSUE_TIMEOUT_EN
  fpu_issue_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk      (clk),
    .rst_b    (rst_b),
    .i_clr    (r_state == ISSUE),
    .i_wait   (r_state == WAIT),
    .i_done   (fpu_done),
    .o_expire (w_expire),
    .o_err    (w_err)
  );
`else
  assign w_expire = 1'b0;
  assign w_err    = 1'b0;
`endif

  // rst_b gating keeps stall low while reset is held even if decode asserts fpu_or_alu
  assign w_accept    = rst_b && (r_state == IDLE) && fpu_or_alu && !halted && !w_err;
  assign stall       = (r_state == ISSUE) || (r_state == WAIT) || w_accept || w_err;
  assign busy        = r_state != IDLE;
  assign fpu_start   = r_state == ISSUE;
  assign fp_wr_en    = (r_state == WB) && r_fpw;
  assign int_wr_en   = (r_state == WB) && !r_fpw;
  assign fpu_op      = r_op;
  assign fpu_a       = r_a;
  assign fpu_b       = r_b;
  assign wr_addr     = r_dest;
  assign wr_data     = r_res;
  assign timeout_err = w_err;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state <= IDLE;
      r_fpw   <= 1'b0;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_dest  <= '0;
    end else begin
      unique case (r_state)
        IDLE: if (w_accept) begin
          r_op    <= fpu_opcode;
          r_a     <= fs_data;
          r_b     <= ft_data;
          r_dest  <= dest_addr;
          r_fpw   <= fp_write_en;
          r_state <= ISSUE;
        end
        ISSUE: r_state <= WAIT;
        WAIT: if (fpu_done) begin
          r_res   <= fpu_result;
          r_state <= WB;
        end else if (w_expire) r_state <= IDLE;
        WB: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// tb_fpu_issue_ctrl: directed table of per-cycle vectors plus hand sequences for
// slow FPU, async reset mid-operation and (with FPU_ISSUE_TIMEOUT_EN) the watchdog.
module tb_fpu_issue_ctrl;
`ifdef FPU_ISSUE_TIMEOUT_EN
  localparam int K = 8;
`else
  localparam int K = 10;
`endif

  logic        clk = 1'b0, rst_b = 1'b0;
  logic        fpu_or_alu = 1'b0, fp_write_en = 1'b0, halted = 1'b0, fpu_done = 1'b0;
  logic [3:0]  fpu_opcode = '0, fpu_op;
  logic [31:0] fs_data = '0, ft_data = '0, fpu_result = '0, fpu_a, fpu_b, wr_data;
  logic [4:0]  dest_addr = '0, wr_addr;
  logic        fpu_start, stall, fp_wr_en, int_wr_en, busy, timeout_err;

  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  fpu_issue_ctrl #(.DATA_W(32), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_b(rst_b), .fpu_or_alu(fpu_or_alu), .fp_write_en(fp_write_en),
    .fpu_opcode(fpu_opcode), .halted(halted), .fs_data(fs_data), .ft_data(ft_data),
    .dest_addr(dest_addr), .fpu_start(fpu_start), .fpu_op(fpu_op), .fpu_a(fpu_a),
    .fpu_b(fpu_b), .fpu_done(fpu_done), .fpu_result(fpu_result), .stall(stall),
    .fp_wr_en(fp_wr_en), .int_wr_en(int_wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .timeout_err(timeout_err)
  );

  typedef struct {
    logic        ov, fw, h, d;
    logic [3:0]  oc;
    logic [31:0] fs, ft;
    logic [4:0]  ds;
    logic [31:0] rs;
    logic [4:0]  e_ctl;
    logic [3:0]  e_op;
    logic [31:0] e_a, e_b;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
  } vec_t;
  vec_t tv[$];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  task automatic row(input logic ov, fw, h, d, input logic [3:0] oc,
                     input logic [31:0] fs, ft, input logic [4:0] ds, input logic [31:0] rs,
                     input logic [4:0] ec, input logic [3:0] eo, input logic [31:0] ea, eb,
                     input logic [4:0] ead, input logic [31:0] edat);
    tv.push_back('{ov, fw, h, d, oc, fs, ft, ds, rs, ec, eo, ea, eb, ead, edat});
  endtask

  task automatic drive(input logic ov, fw, h, d, input logic [3:0] oc,
                       input logic [31:0] fs, ft, input logic [4:0] ds, input logic [31:0] rs);
    fpu_or_alu = ov; fp_write_en = fw; halted = h; fpu_done = d; fpu_opcode = oc;
    fs_data = fs; ft_data = ft; dest_addr = ds; fpu_result = rs;
  endtask

  function automatic logic [31:0] ctl();
    return {27'b0, stall, busy, fpu_start, fp_wr_en, int_wr_en};
  endfunction

  initial begin
    int stalls, wrs, wb_cyc, starts;
    logic [31:0] wb_dat;
    logic stall_all;

    // ctl bits: {stall, busy, fpu_start, fp_wr_en, int_wr_en}
    row(1,1,0,0,4'h1,32'h3F800000,32'h40000000,5'd5,0,            5'b10000,4'h0,32'h0,32'h0,5'd0,32'h0);
    row(0,0,0,0,4'h0,0,0,5'd0,0,                                   5'b11100,4'h1,32'h3F800000,32'h40000000,5'd5,32'h0);
    row(0,0,0,1,4'h0,0,0,5'd0,32'h40400000,                        5'b11000,4'h1,32'h3F800000,32'h40000000,5'd5,32'h0);
    row(1,0,0,0,4'h2,32'hAAAA5555,32'h0F0F0F0F,5'd9,0,             5'b01010,4'h1,32'h3F800000,32'h40000000,5'd5,32'h40400000);
    row(1,0,0,0,4'h2,32'hAAAA5555,32'h0F0F0F0F,5'd9,0,             5'b10000,4'h1,32'h3F800000,32'h40000000,5'd5,32'h40400000);
    row(0,0,0,0,4'h0,0,0,5'd0,0,                                   5'b11100,4'h2,32'hAAAA5555,32'h0F0F0F0F,5'd9,32'h40400000);
    row(0,0,0,1,4'h0,0,0,5'd0,32'h12345678,                        5'b11000,4'h2,32'hAAAA5555,32'h0F0F0F0F,5'd9,32'h40400000);
    row(0,0,0,0,4'h0,0,0,5'd0,0,                                   5'b01001,4'h2,32'hAAAA5555,32'h0F0F0F0F,5'd9,32'h12345678);
    row(0,0,0,1,4'h0,0,0,5'd0,32'hDEADBEEF,                        5'b00000,4'h2,32'hAAAA5555,32'h0F0F0F0F,5'd9,32'h12345678);
    row(1,1,1,0,4'h3,32'hFFFFFFFF,32'hFFFFFFFF,5'd31,0,            5'b00000,4'h2,32'hAAAA5555,32'h0F0F0F0F,5'd9,32'h12345678);
    row(0,0,0,0,4'h0,0,0,5'd0,0,                                   5'b00000,4'h2,32'hAAAA5555,32'h0F0F0F0F,5'd9,32'h12345678);

    // reset state, with decode asserting an FP instruction meanwhile
    @(negedge clk);
    drive(1,1,0,0,4'h1,32'h1,32'h2,5'd3,32'h4);
    #1;
    chk("rst_ctl", ctl(), 32'h0);
    chk("rst_err", {31'b0, timeout_err}, 32'h0);
    chk("rst_data", wr_data, 32'h0);
    chk("rst_a", fpu_a, 32'h0);
    drive(0,0,0,0,4'h0,0,0,5'd0,0);
    @(negedge clk);
    rst_b = 1'b1;

    foreach (tv[i]) begin
      @(negedge clk);
      drive(tv[i].ov, tv[i].fw, tv[i].h, tv[i].d, tv[i].oc, tv[i].fs, tv[i].ft, tv[i].ds, tv[i].rs);
      #1;
      chk($sformatf("row%0d_ctl", i), ctl(), {27'b0, tv[i].e_ctl});
      chk($sformatf("row%0d_op", i), {28'b0, fpu_op}, {28'b0, tv[i].e_op});
      chk($sformatf("row%0d_a", i), fpu_a, tv[i].e_a);
      chk($sformatf("row%0d_b", i), fpu_b, tv[i].e_b);
      chk($sformatf("row%0d_addr", i), {27'b0, wr_addr}, {27'b0, tv[i].e_addr});
      chk($sformatf("row%0d_data", i), wr_data, tv[i].e_data);
    end

    // slow FPU: done K cycles after the start pulse
    stalls = 0; wrs = 0; wb_cyc = -1; wb_dat = '0;
    for (int c = 0; c < K + 6; c++) begin
      @(negedge clk);
      drive(c == 0, 1'b1, 1'b0, c == K + 1, 4'h4, 32'h11110000, 32'h00002222, 5'd3, 32'hCAFEF00D);
      #1;
      stalls += int'(stall);
      if (fp_wr_en || int_wr_en) begin
        wrs++; wb_cyc = c; wb_dat = wr_data;
      end
    end
    chk("slow_stalls", stalls, K + 2);
    chk("slow_writes", wrs, 1);
    chk("slow_wb_cycle", wb_cyc, K + 2);
    chk("slow_wb_data", wb_dat, 32'hCAFEF00D);
    chk("slow_err", {31'b0, timeout_err}, 32'h0);

    // asynchronous reset while in WAIT
    @(negedge clk);
    drive(1,1,0,0,4'h5,32'h11111111,32'h22222222,5'd7,0);
    @(negedge clk);
    drive(0,0,0,0,4'h0,0,0,5'd0,0);
    @(negedge clk);
    #1;
    chk("mid_busy_pre", {31'b0, busy}, 32'h1);
    #1 rst_b = 1'b0;
    #1;
    chk("mid_rst_ctl", ctl(), 32'h0);
    chk("mid_rst_a", fpu_a, 32'h0);
    chk("mid_rst_op", {28'b0, fpu_op}, 32'h0);
    chk("mid_rst_addr", {27'b0, wr_addr}, 32'h0);
    chk("mid_rst_data", wr_data, 32'h0);
    @(negedge clk);
    rst_b = 1'b1;
    drive(0,0,0,1,4'h0,0,0,5'd0,32'h55555555);
    #1;
    chk("post_rst_done_ctl", ctl(), 32'h0);
    @(negedge clk);
    drive(0,0,0,0,4'h0,0,0,5'd0,0);
    #1;
    chk("post_rst_ctl", ctl(), 32'h0);
    chk("post_rst_data", wr_data, 32'h0);

`ifdef FPU_ISSUE_TIMEOUT_EN
    // FPU never answers: abort after 8 WAIT cycles, then the core stays frozen
    wrs = 0; starts = 0; stall_all = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      drive(c == 0 || c == 12, 1'b1, 1'b0, 1'b0, 4'h6, 32'h7, 32'h8, 5'd4, 0);
      #1;
      if (fp_wr_en || int_wr_en) wrs++;
      if (fpu_start) starts++;
      if (c >= 10 && !stall) stall_all = 1'b0;
      if (c == 9) chk("to_err_before", {31'b0, timeout_err}, 32'h0);
      if (c == 10) chk("to_err_set", {31'b0, timeout_err}, 32'h1);
      if (c == 13) chk("to_busy_frozen", {31'b0, busy}, 32'h0);
    end
    chk("to_writes", wrs, 0);
    chk("to_starts", starts, 1);
    chk("to_stall_held", {31'b0, stall_all}, 32'h1);
    chk("to_err_sticky", {31'b0, timeout_err}, 32'h1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fpu_issue_ctrl.md
# fpu_issue_ctrl

Multi-cycle issue/writeback sequencer sitting directly downstream of the control unit.
- Consumes the floating-point decode signals (FPU-or-ALU select, FP write enable, FPU opcode) plus register operands.
- Holds the pipeline while a multi-cycle FPU computes.
- Routes the returned result to the FP or integer register file in a single write pulse.

## Interface
Parameters:
- DATA_W, 32, operand/result width
- TIMEOUT_CYCLES, 64, max WAIT cycles before abort (used only with FPU_ISSUE_TIMEOUT_EN)

Ports:
- clk  in  1  clock, all state on rising edge
- rst_b  in  1  reset, asynchronous, active-low
- fpu_or_alu  in  1  decoded instruction is an FP instruction
- fp_write_en  in  1  result targets FP regfile (0 = integer regfile, move-from-float)
- fpu_opcode  in  4  FPU operation code from decode
- halted  in  1  core halted; blocks new issue
- fs_data  in  DATA_W  operand A
- ft_data  in  DATA_W  operand B
- dest_addr  in  5  destination register index
- fpu_start  out  1  one-cycle start pulse to FPU
- fpu_op  out  4  latched opcode to FPU
- fpu_a  out  DATA_W  latched operand A
- fpu_b  out  DATA_W  latched operand B
- fpu_done  in  1  FPU result valid (single-cycle pulse)
- fpu_result  in  DATA_W  FPU result
- stall  out  1  hold PC/decode
- fp_wr_en  out  1  FP regfile write pulse
- int_wr_en  out  1  integer regfile write pulse
- wr_addr  out  5  write index
- wr_data  out  DATA_W  write data
- busy  out  1  FSM not IDLE
- timeout_err  out  1  sticky abort flag (tied 0 without macro)

## Operation
States: IDLE, ISSUE, WAIT, WB.

IDLE:
- If fpu_or_alu && !halted:
  - latch fpu_opcode, fs_data, ft_data, dest_addr and fp_write_en.
  - go to ISSUE.
  - stall is 1 combinationally in this cycle.
- Otherwise stay in IDLE with stall=0.

ISSUE:
- fpu_start=1 for exactly this cycle.
- fpu_op, fpu_a and fpu_b are driven from the latches.
- Next state is WAIT.
- fpu_done is ignored in ISSUE; the FPU answers no earlier than the cycle after start.

WAIT:
- On fpu_done, latch fpu_result and go to WB.
- Otherwise stay in WAIT.

WB:
- Exactly one of fp_wr_en or int_wr_en is 1, selected by the latched fp_write_en.
- wr_addr and wr_data are driven from the latches.
- stall=0, so the pipeline advances on this edge.
- Next state is IDLE.

General rules:
- stall=1 in ISSUE and WAIT, and in IDLE when accepting an instruction.
- busy = (state != IDLE).
- Outputs fpu_op, fpu_a, fpu_b, wr_addr and wr_data hold their latched values outside their active states.
- No back-to-back acceptance in WB. A new instruction is sampled only in the following IDLE cycle.
- halted rising during ISSUE/WAIT does not abort: the in-flight operation completes and writes back.
- No arithmetic is performed here. Data passes through at full DATA_W width, with no extension or truncation.

## Timing
- Reset (rst_b=0, any time, including mid-operation):
  - state=IDLE immediately.
  - all outputs 0: stall, busy, fpu_start, fp_wr_en, int_wr_en, timeout_err, and all data/address outputs.
  - any later fpu_done is ignored until a new issue.
- Minimum latency from accept to write pulse is 3 cycles (accept→ISSUE→WAIT→WB) when fpu_done arrives in the first WAIT cycle.
  - Total stall: 3 cycles; the instruction retires on the WB edge.
- Latency with fpu_done k cycles after start: accept + 1 + k cycles to WB.
- fpu_done outside WAIT is dropped, with no state change.

## Configuration
FPU_ISSUE_TIMEOUT_EN, when defined:
- A WAIT-cycle counter of $clog2(TIMEOUT_CYCLES+1) bits clears on entry to WAIT.
- If the counter reaches TIMEOUT_CYCLES without fpu_done:
  - timeout_err is set, and stays set until reset.
  - no write occurs; the FSM returns to IDLE.
  - while timeout_err=1, no new issue is accepted and stall stays 1 (the core is frozen).
- fpu_done arriving in the same cycle the count hits the limit wins: normal WB, no error.

Without the macro:
- WAIT has no bound and no counter.
- timeout_err is tied 0.

## Structure
- Shared package fpu_issue_pkg holds:
  - the state enum typedef (IDLE, ISSUE, WAIT, WB);
  - the TIMEOUT_CYCLES default constant.
- FPU opcode encodings come from the existing shared FPU opcode definitions and are not redefined here.
- One natural sub-module: fpu_issue_timeout (counter plus sticky flag), instantiated only under FPU_ISSUE_TIMEOUT_EN.

## Test plan
- **Basic FP add:** fpu_or_alu=1, fp_write_en=1, opcode ADD, fs=0x3F800000, ft=0x40000000, dest=5; FPU returns 0x40400000 one cycle after start.
  - Expect fpu_start pulse in cycle 2.
  - Expect fp_wr_en=1, wr_addr=5, wr_data=0x40400000 in cycle 4.
  - Expect stall high for cycles 1–3.
- **Move-from-float:** fp_write_en=0, dest=9, fpu_result=0x12345678.
  - Expect int_wr_en=1 and fp_wr_en=0 in WB, wr_data=0x12345678.
- **Slow FPU:** fpu_done 10 cycles after start.
  - Expect stall held 12 cycles and exactly one write pulse.
- **Stray done and halted gating:**
  - fpu_done in IDLE → no write, busy stays 0.
  - fpu_or_alu=1 with halted=1 → no fpu_start, stall=0.
- **Reset mid-operation:** rst_b low for 1 cycle while in WAIT.
  - Expect all outputs 0 asynchronously.
  - A following fpu_done produces no write.
- **Timeout (macro on, TIMEOUT_CYCLES=8):** FPU never answers.
  - Expect timeout_err=1 after 8 WAIT cycles, no write, stall=1 persistently.
  - A new fpu_or_alu is not accepted.
